// File: rtl/t_ff_counter_bank_if.sv
// Control/status bundle for t_ff_counter_bank: mode, load and toggle inputs
// plus the Q/Qb state, terminal count and wrap pulse outputs.
interface t_ff_counter_bank_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qb;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, load, load_val, T,
    input  Q, Qb, tc, wrap
  );

  modport slave (
    input  en, mode, load, load_val, T,
    output Q, Qb, tc, wrap
  );
endinterface

// File: rtl/t_ff_counter_bank.sv
// Parametrised bank of T flip-flops: per-bit toggle, mod-MOD up/down T-chain
// counter, hold and parallel load, with a registered one-cycle wrap pulse.
module t_ff_counter_bank #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MOD     = 2**WIDTH,
  parameter int unsigned RST_VAL = 0
) (
  input  logic                 clk,
  input  logic                 Rst,
  t_ff_counter_bank_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] tmask;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  // T-chain: bit i toggles when every lower bit is 1, which yields Q+1
  always_comb begin
    tmask    = '0;
    tmask[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      tmask[i] = tmask[i-1] & q_q[i-1];
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      q_d = bus.load_val;
    end else if (bus.en) begin
      unique case (mode)
        MODE_HOLD:   q_d = q_q;
        MODE_TOGGLE: q_d = q_q ^ bus.T;
        MODE_UP: begin
          if (q_q >= MAX_V) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q ^ tmask;
          end
        end
        MODE_DOWN: begin
          if (q_q == '0) begin
            q_d    = MAX_V;
            wrap_d = 1'b1;
          end else if ({1'b0, q_q} >= MOD_W) begin
            q_d = MAX_V;
          end else begin
            q_d = q_q - 1'b1;
          end
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Qb   = ~q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = (mode == MODE_UP)   ? (q_q == MAX_V) :
                    (mode == MODE_DOWN) ? (q_q == '0)    : 1'b0;

endmodule

// File: tb/tb_t_ff_counter_bank.sv
// Directed bench for t_ff_counter_bank with WIDTH=4, MOD=10, RST_VAL=0.
module tb_t_ff_counter_bank;
  logic clk;
  logic Rst;
  int   errors;
  int   checks;

  t_ff_counter_bank_if #(.WIDTH(4)) bus ();

  t_ff_counter_bank #(.WIDTH(4), .MOD(10), .RST_VAL(0)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    Rst          = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 2'b00;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.T        = '0;
    #3;
    chk("rst_q", bus.Q, 4'h0);
    chk("rst_qb", bus.Qb, 4'hF);
    chk("rst_wrap", {3'b0, bus.wrap}, 4'h0);
    step();
    Rst = 1'b1;

    // async reset mid-cycle from Q=A
    do_load(4'hA);
    chk("load_a", bus.Q, 4'hA);
    #2 Rst = 1'b0;
    #1;
    chk("async_q", bus.Q, 4'h0);
    chk("async_qb", bus.Qb, 4'hF);
    chk("async_wrap", {3'b0, bus.wrap}, 4'h0);
    step();
    Rst = 1'b1;
    step();
    chk("post_rel_q", bus.Q, 4'h0);

    // toggle mode
    bus.en   = 1'b1;
    bus.mode = 2'b01;
    bus.T    = 4'b0101;
    step(); chk("tog1", bus.Q, 4'h5);
    step(); chk("tog2", bus.Q, 4'h0);
    step(); chk("tog3", bus.Q, 4'h5);
    bus.T = 4'h0;
    step(); chk("tog_hold", bus.Q, 4'h5);
    chk("tog_wrap", {3'b0, bus.wrap}, 4'h0);
    bus.T = 4'hF;
    step(); chk("tog_all", bus.Q, 4'hA);
    #1 chk("tog_tc", {3'b0, bus.tc}, 4'h0);

    // up count, modulo 10
    do_load(4'h0);
    bus.mode = 2'b10;
    #1 chk("up_tc0", {3'b0, bus.tc}, 4'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("up_q%0d", k), bus.Q, 4'(k % 10));
      chk($sformatf("up_wrap%0d", k), {3'b0, bus.wrap}, {3'b0, (k % 10) == 0});
      chk($sformatf("up_tc%0d", k), {3'b0, bus.tc}, {3'b0, (k % 10) == 9});
    end

    // down count
    bus.mode = 2'b11;
    do_load(4'h1);
    step(); chk("dn_q0", bus.Q, 4'h0);
    chk("dn_tc0", {3'b0, bus.tc}, 4'h1);
    chk("dn_w0", {3'b0, bus.wrap}, 4'h0);
    step(); chk("dn_q9", bus.Q, 4'h9);
    chk("dn_w9", {3'b0, bus.wrap}, 4'h1);
    step(); chk("dn_q8", bus.Q, 4'h8);
    chk("dn_w8", {3'b0, bus.wrap}, 4'h0);
    do_load(4'hC);
    chk("dn_ld12", bus.Q, 4'hC);
    step(); chk("dn_oor_q", bus.Q, 4'h9);
    chk("dn_oor_w", {3'b0, bus.wrap}, 4'h0);

    // out-of-range value counting up wraps to 0
    bus.mode = 2'b10;
    do_load(4'hD);
    step(); chk("up_oor_q", bus.Q, 4'h0);
    chk("up_oor_w", {3'b0, bus.wrap}, 4'h1);

    // priority
    bus.en = 1'b0;
    do_load(4'h3);
    chk("pri_ld_en0", bus.Q, 4'h3);
    bus.en = 1'b1;
    do_load(4'h9);
    chk("pri_tc9", {3'b0, bus.tc}, 4'h1);
    do_load(4'h6);
    chk("pri_ld_up", bus.Q, 4'h6);
    chk("pri_ld_w", {3'b0, bus.wrap}, 4'h0);
    bus.en = 1'b0;
    step(); chk("pri_en0", bus.Q, 4'h6);
    bus.en = 1'b1;

    // reset at Q=9 during up count suppresses the wrap
    do_load(4'h8);
    step(); chk("mid_q9", bus.Q, 4'h9);
    #2 Rst = 1'b0;
    #1;
    chk("mid_rst_q", bus.Q, 4'h0);
    step();
    chk("mid_rst_w", {3'b0, bus.wrap}, 4'h0);
    chk("mid_hold_q", bus.Q, 4'h0);
    Rst = 1'b1;
    step(); chk("resume_q", bus.Q, 4'h1);
    chk("resume_w", {3'b0, bus.wrap}, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
